// File: rtl/xeng_fmt_pkg.sv
// rtl/xeng_fmt_pkg.sv - shared format-mode encodings and saturation helper
package xeng_fmt_pkg;

    // Bit 1: input is offset-binary; bit 0: output is offset-binary.
    localparam logic [1:0] MODE_S2S = 2'b00;
    localparam logic [1:0] MODE_S2U = 2'b01;
    localparam logic [1:0] MODE_U2S = 2'b10;
    localparam logic [1:0] MODE_U2U = 2'b11;

    // Symmetric saturation magnitude for a signed field of the given width.
    function automatic int sat_lim(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

endpackage

// File: rtl/conv_fmt_lane.sv
// rtl/conv_fmt_lane.sv - single-channel flip, round-half-up, symmetric saturate and flip
module conv_fmt_lane
    import xeng_fmt_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 4
) (
    input  logic [IN_W-1:0]  din,
    input  logic             in_ob,
    input  logic             out_ob,
    output logic [OUT_W-1:0] dout,
    output logic             ovf
);

    localparam int D = IN_W - OUT_W;
    localparam logic signed [IN_W:0] POS = (IN_W + 1)'(sat_lim(OUT_W));
    localparam logic signed [IN_W:0] NEG = -POS;

    logic [IN_W-1:0]        s2c;
    logic signed [IN_W:0]   ext;
    logic signed [IN_W:0]   rnd;
    logic [OUT_W-1:0]       sat;

    assign s2c = {din[IN_W-1] ^ in_ob, din[IN_W-2:0]};
    assign ext = $signed({s2c[IN_W-1], s2c});

    // One guard bit keeps the half-LSB addition from overflowing at the positive end.
    generate
        if (D > 0) begin : g_round
            localparam logic signed [IN_W:0] HALF = (IN_W + 1)'(1) << (D - 1);
            assign rnd = (ext + HALF) >>> D;
        end else begin : g_exact
            assign rnd = ext;
        end
    endgenerate

    always_comb begin
        ovf = 1'b0;
        sat = rnd[OUT_W-1:0];
        if (rnd > POS) begin
            sat = POS[OUT_W-1:0];
            ovf = 1'b1;
        end else if (rnd < NEG) begin
            sat = NEG[OUT_W-1:0];
            ovf = 1'b1;
        end
    end

    assign dout = {sat[OUT_W-1] ^ out_ob, sat[OUT_W-2:0]};

endmodule

// File: rtl/conv_fmt_pipe.sv
// rtl/conv_fmt_pipe.sv - pipelined multi-channel sample-format converter with overflow counting
module conv_fmt_pipe
    import xeng_fmt_pkg::*;
#(
    parameter int N_CHAN  = 4,
    parameter int IN_W    = 8,
    parameter int OUT_W   = 4,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    input  logic                      sync_in,
    input  logic                      din_valid,
    input  logic [N_CHAN*IN_W-1:0]    din,
    input  logic [1:0]                mode_in,
    output logic [N_CHAN*OUT_W-1:0]   dout,
    output logic                      dout_valid,
    output logic                      sync_out,
    output logic [N_CHAN-1:0]         ovf_out,
    output logic [CNT_W-1:0]          ovf_count
);

    logic [1:0]                mode_q;
    logic [1:0]                mode_cur;
    logic [N_CHAN*OUT_W-1:0]   lane_dout;
    logic [N_CHAN-1:0]         lane_ovf;
    logic [N_CHAN*OUT_W-1:0]   dat_q [LATENCY];
    logic [N_CHAN-1:0]         ovf_q [LATENCY];
    logic [LATENCY-1:0]        vld_q;
    logic [LATENCY-1:0]        syn_q;
    logic [CNT_W:0]            pop;
    logic [CNT_W:0]            cnt_sum;

    // A sync cycle's mode applies to the sample presented alongside it.
    assign mode_cur = sync_in ? mode_in : mode_q;

    generate
        for (genvar c = 0; c < N_CHAN; c++) begin : g_lane
            conv_fmt_lane #(
                .IN_W  (IN_W),
                .OUT_W (OUT_W)
            ) u_lane (
                .din    (din[c*IN_W +: IN_W]),
                .in_ob  (mode_cur[1]),
                .out_ob (mode_cur[0]),
                .dout   (lane_dout[c*OUT_W +: OUT_W]),
                .ovf    (lane_ovf[c])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_S2S;
            vld_q  <= '0;
            syn_q  <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
                ovf_q[i] <= '0;
            end
        end else if (ce) begin
            if (sync_in) begin
                mode_q <= mode_in;
            end
            dat_q[0] <= lane_dout;
            ovf_q[0] <= lane_ovf;
            vld_q[0] <= din_valid;
            syn_q[0] <= sync_in;
            for (int i = 1; i < LATENCY; i++) begin
                dat_q[i] <= dat_q[i-1];
                ovf_q[i] <= ovf_q[i-1];
                vld_q[i] <= vld_q[i-1];
                syn_q[i] <= syn_q[i-1];
            end
        end
    end

    assign dout       = dat_q[LATENCY-1];
    assign ovf_out    = ovf_q[LATENCY-1];
    assign dout_valid = vld_q[LATENCY-1];
    assign sync_out   = syn_q[LATENCY-1];

    // Extra top bit of cnt_sum detects overflow so the counter sticks at all-ones.
    always_comb begin
        pop = '0;
        for (int c = 0; c < N_CHAN; c++) begin
            pop = pop + (CNT_W + 1)'(ovf_out[c]);
        end
        cnt_sum = {1'b0, ovf_count} + pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (ce && dout_valid) begin
            ovf_count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_conv_fmt_pipe.sv
// tb/tb_conv_fmt_pipe.sv - randomized and directed self-checking bench for conv_fmt_pipe
module tb_conv_fmt_pipe;

    localparam int N   = 2;
    localparam int IW  = 8;
    localparam int OW  = 4;
    localparam int LAT = 2;
    localparam int CW  = 6;
    localparam int DW  = N * IW;
    localparam int QW  = N * OW;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int VW  = QW + N + 2 + CW;

    typedef struct packed {
        logic [QW-1:0] dout;
        logic [N-1:0]  ovf;
        logic          valid;
        logic          sync;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ce = 1'b0;
    logic          sync_in = 1'b0;
    logic          din_valid = 1'b0;
    logic [DW-1:0] din = '0;
    logic [1:0]    mode_in = 2'b00;
    logic [QW-1:0] dout;
    logic          dout_valid;
    logic          sync_out;
    logic [N-1:0]  ovf_out;
    logic [CW-1:0] ovf_count;

    int   n_checks = 0;
    int   n_fail = 0;
    ent_t cur;
    ent_t pend[$];
    int   cnt_m;
    logic [1:0] mode_m;

    always #5 clk = ~clk;

    conv_fmt_pipe #(
        .N_CHAN  (N),
        .IN_W    (IW),
        .OUT_W   (OW),
        .LATENCY (LAT),
        .CNT_W   (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .sync_in    (sync_in),
        .din_valid  (din_valid),
        .din        (din),
        .mode_in    (mode_in),
        .dout       (dout),
        .dout_valid (dout_valid),
        .sync_out   (sync_out),
        .ovf_out    (ovf_out),
        .ovf_count  (ovf_count)
    );

    wire [VW-1:0] obs = {dout, ovf_out, dout_valid, sync_out, ovf_count};

    // Reference conversion from numeric sample values: decode, divide with floor, clamp, re-encode.
    function automatic ent_t ref_entry(input logic [DW-1:0] d, input logic [1:0] m,
                                       input logic v, input logic s);
        ent_t e;
        e = '0;
        e.valid = v;
        e.sync  = s;
        for (int c = 0; c < N; c++) begin
            int raw, val, t, q, lim, dv;
            raw = int'(d[c*IW +: IW]);
            if (m[1]) val = raw - (1 << (IW - 1));
            else      val = (raw >= (1 << (IW - 1))) ? raw - (1 << IW) : raw;
            dv  = 1 << (IW - OW);
            t   = val + dv / 2;
            q   = (t >= 0) ? t / dv : -((-t + dv - 1) / dv);
            lim = (1 << (OW - 1)) - 1;
            e.ovf[c] = (q > lim) || (q < -lim);
            if (q > lim)  q = lim;
            if (q < -lim) q = -lim;
            if (m[0]) q = q + (1 << (OW - 1));
            e.dout[c*OW +: OW] = q[OW-1:0];
        end
        return e;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {cur.dout, cur.ovf, cur.valid, cur.sync, CW'(cnt_m)};
    endfunction

    task automatic model_reset();
        cur = '0;
        pend.delete();
        for (int i = 0; i < LAT - 1; i++) pend.push_back(ent_t'(0));
        cnt_m  = 0;
        mode_m = 2'b00;
    endtask

    task automatic drive(input logic c, input logic s, input logic v,
                         input logic [DW-1:0] d, input logic [1:0] m);
        ce = c; sync_in = s; din_valid = v; din = d; mode_in = m;
        if (c) begin
            if (cur.valid) begin
                cnt_m = cnt_m + $countones(cur.ovf);
                if (cnt_m > CNT_MAX) cnt_m = CNT_MAX;
            end
            if (s) mode_m = m;
            pend.push_back(ref_entry(d, mode_m, v, s));
            cur = pend.pop_front();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ce  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        din = 16'hFFFF; din_valid = 1'b1; sync_in = 1'b1; mode_in = 2'b11;
        do_reset();
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want 0", obs);
        end
        n_checks++;
        if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_model: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_basic();
        drive(1, 1, 1, {8'hF8, 8'h13}, 2'b00);
        drive(1, 0, 0, 16'h0000, 2'b00);
        n_checks++;
        if ({dout, ovf_out, dout_valid, sync_out} !== {8'h01, 2'b00, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_out: got %h/%b/%b/%b want 01/00/1/1", dout, ovf_out, dout_valid, sync_out);
        end
        drive(1, 0, 0, 16'h0000, 2'b00);
        n_checks++;
        if (sync_out !== 1'b0 || obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL basic_sync_pulse: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_saturate();
        for (int rep = 0; rep < 2; rep++) begin
            logic v;
            v = (rep == 0);
            drive(1, 0, v, {8'h80, 8'h7F}, 2'b00);
            drive(1, 0, 0, 16'h0000, 2'b00);
            n_checks++;
            if ({dout, ovf_out, dout_valid} !== {8'h97, 2'b11, v}) begin
                n_fail++;
                $display("FAIL sat_out rep%0d: got %h/%b/%b want 97/11/%b", rep, dout, ovf_out, dout_valid, v);
            end
            drive(1, 0, 0, 16'h0000, 2'b00);
            n_checks++;
            if (ovf_count !== CW'(2) || obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL sat_count rep%0d: got %0d want 2 (vec %h want %h)", rep, ovf_count, obs, exp_vec());
            end
        end
    endtask

    task automatic test_modes();
        logic [1:0] modes [3];
        logic [7:0] ins [3];
        logic [3:0] outs [3];
        modes = '{2'b01, 2'b10, 2'b11};
        ins   = '{8'h13, 8'h93, 8'h93};
        outs  = '{4'h9, 4'h1, 4'h9};
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, {8'h00, ins[i]}, modes[i]);
            drive(1, 0, 0, 16'h0000, 2'b00);
            n_checks++;
            if (dout[3:0] !== outs[i] || obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL mode_%b: got ch0=%h (vec %h) want ch0=%h (vec %h)", modes[i], dout[3:0], obs, outs[i], exp_vec());
            end
        end
    endtask

    task automatic test_mode_ignore();
        drive(1, 1, 0, 16'h0000, 2'b00);
        drive(1, 0, 1, {8'h00, 8'h13}, 2'b01);
        drive(1, 0, 0, 16'h0000, 2'b01);
        n_checks++;
        if (dout[3:0] !== 4'h1 || obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL mode_nosync: got ch0=%h want 1", dout[3:0]);
        end
        drive(1, 1, 1, {8'h00, 8'h13}, 2'b01);
        drive(1, 0, 0, 16'h0000, 2'b10);
        n_checks++;
        if (dout[3:0] !== 4'h9 || obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL mode_sync_same: got ch0=%h want 9", dout[3:0]);
        end
    endtask

    task automatic test_ce_hold();
        for (int i = 0; i < 15; i++) begin
            logic c;
            c = !(i >= 6 && i < 9);
            drive(c, ($urandom_range(0, 3) == 0), 1'b1, 16'($urandom), 2'($urandom));
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL ce_hold step%0d ce=%b: got %h want %h", i, c, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
                  1'($urandom), 16'($urandom), 2'($urandom));
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL random step%0d: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_reset_inflight();
        drive(1, 1, 1, {8'h80, 8'h7F}, 2'b11);
        drive(1, 0, 1, {8'h80, 8'h7F}, 2'b11);
        do_reset();
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_inflight: got %h want 0", obs);
        end
        drive(1, 0, 1, {8'h00, 8'h13}, 2'b11);
        n_checks++;
        if (dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_latency: got valid=%b want 0", dout_valid);
        end
        drive(1, 0, 0, 16'h0000, 2'b11);
        n_checks++;
        if (dout[3:0] !== 4'h1 || dout_valid !== 1'b1 || obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_mode00: got ch0=%h valid=%b want 1/1", dout[3:0], dout_valid);
        end
    endtask

    task automatic test_count_sat();
        do_reset();
        for (int i = 0; i < 31; i++) drive(1, (i == 0), 1, {8'h80, 8'h7F}, 2'b00);
        drive(1, 0, 0, 16'h0000, 2'b00);
        drive(1, 0, 0, 16'h0000, 2'b00);
        n_checks++;
        if (ovf_count !== CW'(62)) begin
            n_fail++;
            $display("FAIL count_62: got %0d want 62", ovf_count);
        end
        drive(1, 0, 1, {8'h80, 8'h7F}, 2'b00);
        drive(1, 0, 0, 16'h0000, 2'b00);
        drive(1, 0, 0, 16'h0000, 2'b00);
        n_checks++;
        if (ovf_count !== CW'(CNT_MAX)) begin
            n_fail++;
            $display("FAIL count_sat: got %0d want %0d", ovf_count, CNT_MAX);
        end
        for (int i = 0; i < 3; i++) drive(1, 0, 1, {8'h80, 8'h7F}, 2'b00);
        drive(1, 0, 0, 16'h0000, 2'b00);
        drive(1, 0, 0, 16'h0000, 2'b00);
        n_checks++;
        if (ovf_count !== CW'(CNT_MAX) || obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL count_nowrap: got %0d want %0d", ovf_count, CNT_MAX);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_saturate();
        test_modes();
        test_mode_ignore();
        test_ce_hold();
        test_random();
        test_reset_inflight();
        test_count_sat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
